wasca_buttons: RTL and testbench
================================

# wasca_buttons

Avalon-MM slave input port that pairs with the LED output port on the same system interconnect. It samples WIDTH external button/switch pins through a two-flop synchronizer and a per-bit debounce filter, and exposes the debounced level to the CPU. It latches qualifying edges into a write-1-to-clear capture register and raises a level interrupt when any unmasked capture bit is set.

## Interface

Parameters:
- WIDTH, 4: number of input pins, 1..32.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from the debounced level before it is accepted, 1..65535.
- EDGE_TYPE, 2: edge type captured. 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, {WIDTH{1'b0}}: reset value of the synchronizer flops and the debounced level. Set to all-ones for active-low buttons idling high.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous pin inputs.
- readdata  out  32  read data, combinational, zero wait states, read latency 0.
- irq  out  1  level interrupt, active high.

## Operation

- Register map (all bits above WIDTH read 0; writes to them are ignored):
  - 0, DATA: read-only debounced level `db`. Writes are ignored.
  - 1: reserved. Reads 0; writes are ignored.
  - 2, IRQMASK: read/write `irq_mask`. A write occurs when chipselect=1 and write_n=0; it loads writedata[WIDTH-1:0].
  - 3, EDGECAP: reads `edge_cap`. A write clears every bit i where writedata[i]=1.
- Synchronizer: `s1 <= in_port; s2 <= s1` on every clock.
- Debounce, per bit i, with counter `cnt[i]` of width ceil(log2(DEBOUNCE_CYCLES)) (minimum 1):
  - If s2[i]==db[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: db[i] <= s2[i] and cnt[i] <= 0. This is an update event.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and is never accepted.
- Edge capture, per bit i:
  - The bit is set on the same clock edge as an update event that qualifies: a rising event (db 0->1) for EDGE_TYPE 0, a falling event (1->0) for EDGE_TYPE 1, either event for EDGE_TYPE 2.
  - If a set and a write-1-clear land on the same cycle, the set wins and the bit stays 1.
  - A bit that is already set stays set on further edges; the register does not count edges.
- irq = |(edge_cap & irq_mask). It is combinational from registers only and never glitches on bus inputs.
- readdata is decoded combinationally from address. It is valid whenever chipselect is high and undefined otherwise; it is driven as the mux output regardless of chipselect.

## Timing

- Reset values: s1, s2 and db = RESET_LEVEL; cnt = 0; irq_mask = 0; edge_cap = 0; irq = 0. readdata equals the decode of the reset registers, e.g. RESET_LEVEL at address 0.
- Clock edges are numbered from the first edge that samples a new pin level as edge 1.
  - s2 holds the new level after edge 2.
  - db and edge_cap update at edge 2+DEBOUNCE_CYCLES.
  - irq goes high after the same edge if the bit is unmasked.
  - With the default parameters, irq rises 18 clocks after the pin change.
- An IRQMASK write takes effect on irq in the cycle after the write edge.
- An EDGECAP clear drops irq after the write edge, unless a set occurs on the same edge.
- Asserting reset_n mid-debounce immediately returns db to RESET_LEVEL, clears cnt and edge_cap, and deasserts irq. No edge is generated by reset itself.

## Test plan

- Reset with RESET_LEVEL=0 and in_port=0: readdata=0 at every address and irq=0. Write IRQMASK=4'hF, then read address 2: returns 0x0000000F.
- in_port[0] rises and holds high, default parameters: DATA bit 0 reads 1 exactly 18 edges after the change, EDGECAP reads 0x1, and irq=1. Write EDGECAP=0x1: irq drops the next cycle.
- in_port[1] pulses high for 10 cycles with DEBOUNCE_CYCLES=16: DATA stays 0, EDGECAP stays 0, irq stays 0.
- EDGE_TYPE=1: a rise on bit 2 updates DATA but leaves EDGECAP at 0. A later fall sets EDGECAP=0x4. With IRQMASK=0 irq stays 0; writing IRQMASK=0x4 asserts irq the next cycle.
- An EDGECAP write of 0x8 on the same edge as a bit-3 update event: EDGECAP bit 3 reads 1 afterwards.
- reset_n is asserted 5 cycles into a debounce run: cnt clears and DATA returns to RESET_LEVEL. After release, a stable pin equal to RESET_LEVEL produces no capture and no irq.

Source files
------------

// File: rtl/wasca_buttons.sv
// Avalon-MM button/switch input port: 2-flop sync, per-bit debounce, W1C edge capture, masked level irq.
// readdata is a zero-wait combinational decode; irq depends on registers only.
module wasca_buttons #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, db;
  logic [WIDTH-1:0] upd, cap_set, cap_clr;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign cap_clr      = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // Debounce and edge qualification; s2 is the post-update level of db on an update event.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign upd[i]     = (s2[i] != db[i]) && (cnt[i] == CNT_MAX);
    assign cnt_nxt[i] = ((s2[i] == db[i]) || upd[i]) ? '0 : cnt[i] + CW'(1);
    assign cap_set[i] = upd[i] && ((EDGE_TYPE == 0) ? s2[i] :
                                   (EDGE_TYPE == 1) ? !s2[i] : 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= RESET_LEVEL;
      s2       <= RESET_LEVEL;
      db       <= RESET_LEVEL;
      irq_mask <= '0;
      edge_cap <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      db       <= (db & ~upd) | (s2 & upd);
      // A set on the same edge as a write-1-clear wins.
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wasca_buttons.sv
// Directed bench: dut_a uses defaults (any edge), dut_b captures falling edges only.
module tb_wasca_buttons;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_b;
  logic [3:0]  pin_a, pin_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wasca_buttons dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(pin_a),
    .readdata(rd_a), .irq(irq_a)
  );

  wasca_buttons #(.EDGE_TYPE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(pin_b),
    .readdata(rd_b), .irq(irq_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read check: readdata is combinational, so set address and sample shortly after.
  task automatic rd_chk(input bit sel_b, input logic [1:0] a, input logic [31:0] exp,
                        input string tag);
    address = a;
    #1;
    check_eq(tag, sel_b ? rd_b : rd_a, exp);
  endtask

  task automatic bus_wr(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = !sel_b;
    cs_b      = sel_b;
    tick(1);
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; write_n = 1'b1; writedata = '0;
    cs_a = 1'b0; cs_b = 1'b0; pin_a = '0; pin_b = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    for (int a = 0; a < 4; a++) rd_chk(0, 2'(a), 32'h0, $sformatf("reset_rd_a%0d", a));
    check_eq("reset_irq_a", {31'b0, irq_a}, 32'h0);
    rd_chk(1, 2'd0, 32'h0, "reset_rd_b0");
    check_eq("reset_irq_b", {31'b0, irq_b}, 32'h0);

    bus_wr(0, 2'd2, 32'hFFFF_FFFF);
    rd_chk(0, 2'd2, 32'h0000_000F, "irqmask_rd");
    bus_wr(0, 2'd0, 32'hF);
    rd_chk(0, 2'd0, 32'h0, "data_ro");

    // Bit 0 rise: accepted exactly 18 edges after the change
    pin_a[0] = 1'b1;
    tick(17);
    rd_chk(0, 2'd0, 32'h0, "rise_edge17_data");
    check_eq("rise_edge17_irq", {31'b0, irq_a}, 32'h0);
    tick(1);
    rd_chk(0, 2'd0, 32'h1, "rise_edge18_data");
    rd_chk(0, 2'd3, 32'h1, "rise_edgecap");
    check_eq("rise_irq", {31'b0, irq_a}, 32'h1);
    address = 2'd3; writedata = 32'h1; write_n = 1'b0; cs_a = 1'b1;
    #1;
    check_eq("irq_before_clr_edge", {31'b0, irq_a}, 32'h1);
    tick(1);
    write_n = 1'b1; cs_a = 1'b0;
    check_eq("irq_after_clr", {31'b0, irq_a}, 32'h0);
    rd_chk(0, 2'd3, 32'h0, "edgecap_cleared");

    // 10-cycle glitch on bit 1 is rejected
    pin_a[1] = 1'b1;
    tick(10);
    pin_a[1] = 1'b0;
    tick(30);
    rd_chk(0, 2'd0, 32'h1, "glitch_data");
    rd_chk(0, 2'd3, 32'h0, "glitch_edgecap");
    check_eq("glitch_irq", {31'b0, irq_a}, 32'h0);

    // Falling-edge-only instance
    pin_b[2] = 1'b1;
    tick(20);
    rd_chk(1, 2'd0, 32'h4, "fall_b_rise_data");
    rd_chk(1, 2'd3, 32'h0, "fall_b_rise_edgecap");
    pin_b[2] = 1'b0;
    tick(20);
    rd_chk(1, 2'd0, 32'h0, "fall_b_fall_data");
    rd_chk(1, 2'd3, 32'h4, "fall_b_edgecap");
    check_eq("fall_b_irq_masked", {31'b0, irq_b}, 32'h0);
    address = 2'd2; writedata = 32'h4; write_n = 1'b0; cs_b = 1'b1;
    #1;
    check_eq("fall_b_irq_pre_mask_edge", {31'b0, irq_b}, 32'h0);
    tick(1);
    write_n = 1'b1; cs_b = 1'b0;
    check_eq("fall_b_irq_unmasked", {31'b0, irq_b}, 32'h1);

    // Clear of bit 3 lands on the same edge as its update event: set wins
    pin_a[3] = 1'b1;
    tick(17);
    address = 2'd3; writedata = 32'h8; write_n = 1'b0; cs_a = 1'b1;
    tick(1);
    write_n = 1'b1; cs_a = 1'b0;
    rd_chk(0, 2'd3, 32'h8, "set_wins_edgecap");
    rd_chk(0, 2'd0, 32'h9, "set_wins_data");
    check_eq("set_wins_irq", {31'b0, irq_a}, 32'h1);

    // Reset 5 cycles into a debounce run of the falling bit 0
    pin_a[0] = 1'b0;
    tick(7);
    reset_n = 1'b0;
    #1;
    rd_chk(0, 2'd0, 32'h0, "rst_mid_data");
    rd_chk(0, 2'd3, 32'h0, "rst_mid_edgecap");
    rd_chk(0, 2'd2, 32'h0, "rst_mid_irqmask");
    check_eq("rst_mid_irq", {31'b0, irq_a}, 32'h0);
    pin_a = '0;
    tick(2);
    reset_n = 1'b1;
    bus_wr(0, 2'd2, 32'hF);
    tick(30);
    rd_chk(0, 2'd0, 32'h0, "post_rst_data");
    rd_chk(0, 2'd3, 32'h0, "post_rst_edgecap");
    check_eq("post_rst_irq", {31'b0, irq_a}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
